// File: rtl/wishbone_request_slice.sv
// Registered single-outstanding Wishbone (pipelined) request/response slice.
// Optional hung-transfer timeout is built when WISHBONE_REQUEST_SLICE_TIMEOUT_EN is defined.
module wishbone_request_slice #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  // upstream (bridge master) side
  input  logic                      s_cyc,
  input  logic                      s_stb,
  input  logic                      s_we,
  input  logic [ADDRESS_WIDTH-1:0]  s_adr,
  input  logic [DATA_WIDTH-1:0]     s_dat_w,
  input  logic [DATA_WIDTH/8-1:0]   s_sel,
  output logic                      s_stall,
  output logic                      s_ack,
  output logic                      s_err,
  output logic                      s_rty,
  output logic [DATA_WIDTH-1:0]     s_dat_r,
  // downstream (register block) side
  output logic                      m_cyc,
  output logic                      m_stb,
  output logic                      m_we,
  output logic [ADDRESS_WIDTH-1:0]  m_adr,
  output logic [DATA_WIDTH-1:0]     m_dat_w,
  output logic [DATA_WIDTH/8-1:0]   m_sel,
  input  logic                      m_stall,
  input  logic                      m_ack,
  input  logic                      m_err,
  input  logic                      m_rty,
  input  logic [DATA_WIDTH-1:0]     m_dat_r
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT_RESP,
    ST_RESPOND
  } state_e;

  typedef enum logic [1:0] {
    RSP_ACK,
    RSP_ERR,
    RSP_RTY
  } rsp_e;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                   state_q, state_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0]    dat_w_q, dat_w_d;
  logic [SEL_WIDTH-1:0]     sel_q, sel_d;
  rsp_e                     rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0]    dat_r_q, dat_r_d;

  logic busy;
  logic rsp_any;
  logic timeout_hit;

  assign busy    = (state_q == ST_REQUEST) || (state_q == ST_WAIT_RESP);
  assign rsp_any = m_ack || m_err || m_rty;

`ifdef WISHBONE_REQUEST_SLICE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Held at zero while idle so it reads 0 in the first REQUEST cycle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE) begin
      tmo_cnt_d = '0;
    end else if (busy) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // The increment taken this cycle would reach TIMEOUT_CYCLES.
  assign timeout_hit = busy && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State and captured request/response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_w_q <= '0;
      sel_q   <= '0;
      rsp_q   <= RSP_ACK;
      dat_r_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_w_q <= dat_w_d;
      sel_q   <= sel_d;
      rsp_q   <= rsp_d;
      dat_r_q <= dat_r_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_w_d = dat_w_q;
    sel_d   = sel_q;
    rsp_d   = rsp_q;
    dat_r_d = dat_r_q;

    unique case (state_q)
      ST_IDLE: begin
        if (s_cyc && s_stb) begin
          state_d = ST_REQUEST;
          we_d    = s_we;
          adr_d   = s_adr;
          dat_w_d = s_dat_w;
          sel_d   = s_sel;
        end
      end
      ST_REQUEST: begin
        if (!m_stall && rsp_any) begin
          state_d = ST_RESPOND;
        end else if (timeout_hit) begin
          state_d = ST_RESPOND;
        end else if (!m_stall) begin
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (rsp_any || timeout_hit) begin
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A response seen while the request is still stalled is not a valid reply.
    if (busy && state_d == ST_RESPOND) begin
      if (rsp_any && !(state_q == ST_REQUEST && m_stall)) begin
        if (m_err) begin
          rsp_d   = RSP_ERR;
          dat_r_d = '0;
        end else if (m_rty) begin
          rsp_d   = RSP_RTY;
          dat_r_d = '0;
        end else begin
          rsp_d   = RSP_ACK;
          dat_r_d = m_dat_r;
        end
      end else begin
        rsp_d   = RSP_ERR;
        dat_r_d = '0;
      end
    end
  end

  // Outputs decoded from state; the response pulse is dropped if the master abandoned the cycle.
  always_comb begin
    s_stall = 1'b1;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_rty   = 1'b0;
    m_cyc   = 1'b0;
    m_stb   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        s_stall = 1'b0;
      end
      ST_REQUEST: begin
        m_cyc = 1'b1;
        m_stb = 1'b1;
      end
      ST_WAIT_RESP: begin
        m_cyc = 1'b1;
      end
      ST_RESPOND: begin
        s_err = s_cyc && (rsp_q == RSP_ERR);
        s_rty = s_cyc && (rsp_q == RSP_RTY);
        s_ack = s_cyc && (rsp_q == RSP_ACK);
      end
      default: begin
        s_stall = 1'b1;
      end
    endcase
  end

  assign m_we    = we_q;
  assign m_adr   = adr_q;
  assign m_dat_w = dat_w_q;
  assign m_sel   = sel_q;
  assign s_dat_r = dat_r_q;

endmodule

// File: tb/tb_wishbone_request_slice.sv
// Directed self-checking bench for wishbone_request_slice; covers the timeout
// build when WISHBONE_REQUEST_SLICE_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
`timescale 1ns/1ps
module tb_wishbone_request_slice;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w;
  logic [SW-1:0] s_sel;
  logic          s_stall, s_ack, s_err, s_rty;
  logic [DW-1:0] s_dat_r;
  logic          m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat_w;
  logic [SW-1:0] m_sel;
  logic          m_stall, m_ack, m_err, m_rty;
  logic [DW-1:0] m_dat_r;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  wishbone_request_slice #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .s_cyc  (s_cyc),
    .s_stb  (s_stb),
    .s_we   (s_we),
    .s_adr  (s_adr),
    .s_dat_w(s_dat_w),
    .s_sel  (s_sel),
    .s_stall(s_stall),
    .s_ack  (s_ack),
    .s_err  (s_err),
    .s_rty  (s_rty),
    .s_dat_r(s_dat_r),
    .m_cyc  (m_cyc),
    .m_stb  (m_stb),
    .m_we   (m_we),
    .m_adr  (m_adr),
    .m_dat_w(m_dat_w),
    .m_sel  (m_sel),
    .m_stall(m_stall),
    .m_ack  (m_ack),
    .m_err  (m_err),
    .m_rty  (m_rty),
    .m_dat_r(m_dat_r)
  );

  // Handshake bits packed as {s_stall, s_ack, s_err, s_rty, m_cyc, m_stb}.
  function automatic logic [5:0] ctl();
    ctl = {s_stall, s_ack, s_err, s_rty, m_cyc, m_stb};
  endfunction

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    s_adr = '0; s_dat_w = '0; s_sel = '0;
    m_stall = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
    m_dat_r = '0;
  endtask

  // Presents one request in cycle T and returns at the start of cycle T+1.
  task automatic start(input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    step();
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = adr; s_dat_w = dat; s_sel = sel;
    step();
    s_stb = 1'b0; s_we = 1'b0; s_adr = '0; s_dat_w = '0; s_sel = '0;
  endtask

  task automatic finish_xfer();
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    step(); #1;
    checks++; if ({ctl(), s_dat_r, m_we, m_adr, m_dat_w, m_sel} !== '0) begin errors++;
      $display("FAIL reset_outputs: got ctl=%b dat_r=%h adr=%h dat_w=%h sel=%h want all zero", ctl(), s_dat_r, m_adr, m_dat_w, m_sel); end
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_write_zero_wait();
    step();
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 16'h0010; s_dat_w = 32'hA5A5_0F0F; s_sel = 4'hF;
    #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL wr_accept_ctl: got %b want %b", ctl(), 6'b000000); end
    step();
    s_stb = 1'b0; s_we = 1'b0; s_adr = '0; s_dat_w = '0; s_sel = '0; m_ack = 1'b1;
    #1;
    checks++; if (ctl() !== 6'b100011) begin errors++; $display("FAIL wr_t1_ctl: got %b want %b", ctl(), 6'b100011); end
    checks++; if ({m_we, m_adr, m_dat_w, m_sel} !== {1'b1, 16'h0010, 32'hA5A5_0F0F, 4'hF}) begin errors++;
      $display("FAIL wr_t1_req: got we=%b adr=%h dat=%h sel=%h want we=1 adr=0010 dat=a5a50f0f sel=f", m_we, m_adr, m_dat_w, m_sel); end
    step();
    m_ack = 1'b0;
    #1;
    checks++; if (ctl() !== 6'b110000) begin errors++; $display("FAIL wr_t2_ack: got %b want %b", ctl(), 6'b110000); end
    step();
    s_cyc = 1'b0;
    #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL wr_t3_idle: got %b want %b", ctl(), 6'b000000); end
  endtask

  task automatic test_read_stall();
    start(1'b0, 16'h0020, 32'h0, 4'hF);
    m_stall = 1'b1;                                        // T+1
    #1;
    checks++; if (ctl() !== 6'b100011) begin errors++; $display("FAIL rd_t1_ctl: got %b want %b", ctl(), 6'b100011); end
    step();                                                // T+2: ack while stalled must be ignored
    m_ack = 1'b1; m_dat_r = 32'hBAD0_BAD0;
    #1;
    checks++; if (ctl() !== 6'b100011) begin errors++; $display("FAIL rd_t2_ctl: got %b want %b", ctl(), 6'b100011); end
    step();                                                // T+3
    m_ack = 1'b0; m_dat_r = '0;
    #1;
    checks++; if (ctl() !== 6'b100011) begin errors++; $display("FAIL rd_t3_stall_ignores_ack: got %b want %b", ctl(), 6'b100011); end
    checks++; if ({m_we, m_adr} !== {1'b0, 16'h0020}) begin errors++; $display("FAIL rd_t3_req: got we=%b adr=%h want we=0 adr=0020", m_we, m_adr); end
    step();                                                // T+4: slave takes the request
    m_stall = 1'b0;
    #1;
    checks++; if (ctl() !== 6'b100011) begin errors++; $display("FAIL rd_t4_ctl: got %b want %b", ctl(), 6'b100011); end
    step();                                                // T+5: waiting
    #1;
    checks++; if (ctl() !== 6'b100010) begin errors++; $display("FAIL rd_t5_wait: got %b want %b", ctl(), 6'b100010); end
    step();                                                // T+6: ack
    m_ack = 1'b1; m_dat_r = 32'h1234_5678;
    #1;
    checks++; if (ctl() !== 6'b100010) begin errors++; $display("FAIL rd_t6_wait: got %b want %b", ctl(), 6'b100010); end
    step();                                                // T+7: response
    m_ack = 1'b0; m_dat_r = 32'hDEAD_BEEF;
    #1;
    checks++; if (ctl() !== 6'b110000) begin errors++; $display("FAIL rd_t7_ack: got %b want %b", ctl(), 6'b110000); end
    checks++; if (s_dat_r !== 32'h1234_5678) begin errors++; $display("FAIL rd_t7_data: got %h want %h", s_dat_r, 32'h1234_5678); end
    step();
    s_cyc = 1'b0; m_dat_r = '0;
    #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL rd_t8_idle: got %b want %b", ctl(), 6'b000000); end
    checks++; if (s_dat_r !== 32'h1234_5678) begin errors++; $display("FAIL rd_t8_data_hold: got %h want %h", s_dat_r, 32'h1234_5678); end
  endtask

  task automatic test_err_rty();
    start(1'b0, 16'h0040, 32'h0, 4'hF);
    m_ack = 1'b1; m_dat_r = 32'hCAFE_F00D;
    step();
    m_ack = 1'b0; m_dat_r = '0;
    #1;
    checks++; if ({ctl(), s_dat_r} !== {6'b110000, 32'hCAFE_F00D}) begin errors++;
      $display("FAIL ack_read: got ctl=%b dat=%h want ctl=110000 dat=cafef00d", ctl(), s_dat_r); end
    finish_xfer();

    start(1'b0, 16'h0044, 32'h0, 4'hF);
    m_err = 1'b1; m_ack = 1'b1; m_dat_r = 32'hFFFF_0000;
    step();
    m_err = 1'b0; m_ack = 1'b0; m_dat_r = '0;
    #1;
    checks++; if ({ctl(), s_dat_r} !== {6'b101000, 32'h0}) begin errors++;
      $display("FAIL err_over_ack: got ctl=%b dat=%h want ctl=101000 dat=00000000", ctl(), s_dat_r); end
    finish_xfer();

    start(1'b1, 16'h0048, 32'h0000_0001, 4'h1);
    step();                                                // WAIT_RESP
    m_rty = 1'b1; m_dat_r = 32'h5555_5555;
    step();
    m_rty = 1'b0; m_dat_r = '0;
    #1;
    checks++; if ({ctl(), s_dat_r} !== {6'b100100, 32'h0}) begin errors++;
      $display("FAIL rty_only: got ctl=%b dat=%h want ctl=100100 dat=00000000", ctl(), s_dat_r); end
    finish_xfer();
  endtask

  task automatic test_back_to_back();
    step();                                                // T: request A
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 16'h0030; s_dat_w = 32'h1111_1111; s_sel = 4'hF;
    step();                                                // T+1: B presented, must stall
    s_adr = 16'h0034; s_dat_w = 32'h2222_2222; s_sel = 4'h3; m_ack = 1'b1;
    #1;
    checks++; if ({ctl(), m_adr, m_dat_w} !== {6'b100011, 16'h0030, 32'h1111_1111}) begin errors++;
      $display("FAIL b2b_a_req: got ctl=%b adr=%h dat=%h want ctl=100011 adr=0030 dat=11111111", ctl(), m_adr, m_dat_w); end
    step();                                                // T+2: A responds, B still stalled
    m_ack = 1'b0;
    #1;
    checks++; if (ctl() !== 6'b110000) begin errors++; $display("FAIL b2b_a_ack: got %b want %b", ctl(), 6'b110000); end
    step();                                                // T+3: IDLE, B accepted
    #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL b2b_b_accept: got %b want %b", ctl(), 6'b000000); end
    step();                                                // T+4: B downstream
    s_stb = 1'b0; s_adr = '0; s_dat_w = '0; s_sel = '0; m_ack = 1'b1;
    #1;
    checks++; if ({ctl(), m_adr, m_dat_w, m_sel} !== {6'b100011, 16'h0034, 32'h2222_2222, 4'h3}) begin errors++;
      $display("FAIL b2b_b_req: got ctl=%b adr=%h dat=%h sel=%h want ctl=100011 adr=0034 dat=22222222 sel=3", ctl(), m_adr, m_dat_w, m_sel); end
    step();
    m_ack = 1'b0;
    #1;
    checks++; if (ctl() !== 6'b110000) begin errors++; $display("FAIL b2b_b_ack: got %b want %b", ctl(), 6'b110000); end
    finish_xfer();
  endtask

  task automatic test_abort();
    start(1'b1, 16'h0050, 32'h0000_00AA, 4'hF);
    s_cyc = 1'b0; m_stall = 1'b1;                          // T+1: master abandons
    #1;
    checks++; if (ctl() !== 6'b100011) begin errors++; $display("FAIL abort_t1_ctl: got %b want %b", ctl(), 6'b100011); end
    step();                                                // T+2: downstream still completes
    m_stall = 1'b0; m_ack = 1'b1; m_dat_r = 32'h0BAD_0BAD;
    #1;
    checks++; if (ctl() !== 6'b100011) begin errors++; $display("FAIL abort_t2_ctl: got %b want %b", ctl(), 6'b100011); end
    step();                                                // T+3: RESPOND with pulse suppressed
    m_ack = 1'b0; m_dat_r = '0;
    #1;
    checks++; if (ctl() !== 6'b100000) begin errors++; $display("FAIL abort_no_pulse: got %b want %b", ctl(), 6'b100000); end
    step();
    #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL abort_idle: got %b want %b", ctl(), 6'b000000); end
  endtask

  task automatic test_reset_mid_transfer();
    start(1'b0, 16'h0070, 32'h0, 4'hF);
    m_ack = 1'b1; m_dat_r = 32'h3C3C_3C3C;
    step();
    m_ack = 1'b0; m_dat_r = '0;
    #1;
    checks++; if ({ctl(), s_dat_r} !== {6'b110000, 32'h3C3C_3C3C}) begin errors++;
      $display("FAIL rst_pre_read: got ctl=%b dat=%h want ctl=110000 dat=3c3c3c3c", ctl(), s_dat_r); end
    finish_xfer();

    start(1'b1, 16'h0074, 32'h9999_9999, 4'hF);
    step();                                                // WAIT_RESP
    #1;
    checks++; if (ctl() !== 6'b100010) begin errors++; $display("FAIL rst_wait_state: got %b want %b", ctl(), 6'b100010); end
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++; if ({ctl(), s_dat_r, m_we, m_adr, m_dat_w, m_sel} !== '0) begin errors++;
      $display("FAIL rst_mid_outputs: got ctl=%b dat_r=%h adr=%h dat_w=%h sel=%h want all zero", ctl(), s_dat_r, m_adr, m_dat_w, m_sel); end
    step();
    idle_inputs();
    i_rst_n = 1'b1;

    start(1'b0, 16'h0078, 32'h0, 4'hF);
    m_ack = 1'b1; m_dat_r = 32'h0F0F_1234;
    #1;
    checks++; if ({ctl(), m_adr} !== {6'b100011, 16'h0078}) begin errors++;
      $display("FAIL rst_post_req: got ctl=%b adr=%h want ctl=100011 adr=0078", ctl(), m_adr); end
    step();
    m_ack = 1'b0; m_dat_r = '0;
    #1;
    checks++; if ({ctl(), s_dat_r} !== {6'b110000, 32'h0F0F_1234}) begin errors++;
      $display("FAIL rst_post_ack: got ctl=%b dat=%h want ctl=110000 dat=0f0f1234", ctl(), s_dat_r); end
    finish_xfer();
  endtask

`ifdef WISHBONE_REQUEST_SLICE_TIMEOUT_EN
  task automatic test_timeout();
    start(1'b0, 16'h0060, 32'h0, 4'hF);                    // REQUEST entry cycle R
    m_stall = 1'b1;
    for (int i = 0; i < TO; i++) begin
      #1;
      checks++; if (ctl() !== 6'b100011) begin errors++; $display("FAIL tmo_pending_%0d: got %b want %b", i, ctl(), 6'b100011); end
      step();
    end
    #1;                                                    // R+8
    checks++; if ({ctl(), s_dat_r} !== {6'b101000, 32'h0}) begin errors++;
      $display("FAIL tmo_err: got ctl=%b dat=%h want ctl=101000 dat=00000000", ctl(), s_dat_r); end
    finish_xfer();

    start(1'b0, 16'h0064, 32'h0, 4'hF);
    m_stall = 1'b1;
    for (int i = 0; i < TO - 1; i++) step();
    m_stall = 1'b0; m_ack = 1'b1; m_dat_r = 32'h7777_8888; // R+7: response in the timeout cycle
    #1;
    checks++; if (ctl() !== 6'b100011) begin errors++; $display("FAIL tmo_race_req: got %b want %b", ctl(), 6'b100011); end
    step();
    m_ack = 1'b0; m_dat_r = '0;
    #1;
    checks++; if ({ctl(), s_dat_r} !== {6'b110000, 32'h7777_8888}) begin errors++;
      $display("FAIL tmo_race_ack_wins: got ctl=%b dat=%h want ctl=110000 dat=77778888", ctl(), s_dat_r); end
    finish_xfer();
  endtask
`else
  task automatic test_no_timeout();
    int bad_cycle;
    bad_cycle = -1;
    start(1'b0, 16'h0060, 32'h0, 4'hF);
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (bad_cycle < 0 && (s_ack || s_err || s_rty || !m_cyc)) bad_cycle = i;
      step();
    end
    checks++; if (bad_cycle !== -1) begin errors++;
      $display("FAIL no_timeout_hang: got response or m_cyc drop at cycle %0d want none in 1000 cycles", bad_cycle); end
    idle_inputs();
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_write_zero_wait();
    test_read_stall();
    test_err_rty();
    test_back_to_back();
    test_abort();
    test_reset_mid_transfer();
`ifdef WISHBONE_REQUEST_SLICE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
